mul_div_unit: RTL and testbench

- Multi-cycle RV32M execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits in the execute stage beside the single-cycle ALU.
- The hazard/stall logic holds F/D and bubbles E while `busy` is high. The stall length therefore comes from the unit's real completion, not a fixed count.
- Multiply uses a registered product with fixed latency. Divide/remainder use a radix-2 restoring iteration.

---
 rtl/mul_div_unit_pkg.sv | 47 ++++
 rtl/mul_div_unit_if.sv | 28 ++
 rtl/mul_div_unit_div_core.sv | 54 +++++
 rtl/mul_div_unit.sv | 170 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: alucodes, FSM
// state encoding, iteration count and small alucode decode helpers.
package mul_div_unit_pkg;

  localparam int DATA_W   = 32;
  localparam int DIV_ITER = 32;

  typedef logic [4:0] alucode_t;

  // M-extension alucodes: [4:3] = 2'b10 marks the group, [2:0] follows funct3.
  localparam alucode_t ALU_MUL    = 5'b10000;
  localparam alucode_t ALU_MULH   = 5'b10001;
  localparam alucode_t ALU_MULHSU = 5'b10010;
  localparam alucode_t ALU_MULHU  = 5'b10011;
  localparam alucode_t ALU_DIV    = 5'b10100;
  localparam alucode_t ALU_DIVU   = 5'b10101;
  localparam alucode_t ALU_REM    = 5'b10110;
  localparam alucode_t ALU_REMU   = 5'b10111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic is_m_op(input alucode_t code);
    return code[4:3] == 2'b10;
  endfunction

  // DIV/DIVU/REM/REMU
  function automatic logic is_div_op(input alucode_t code);
    return code[2];
  endfunction

  // REM/REMU (only meaningful together with is_div_op)
  function automatic logic is_rem_op(input alucode_t code);
    return code[1];
  endfunction

  // DIV/REM (only meaningful together with is_div_op)
  function automatic logic is_signed_div(input alucode_t code);
    return !code[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage request/response bundle between the pipeline and the
// multiply/divide unit.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = DATA_W
);
  logic            start;
  alucode_t        alucode;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  // Pipeline side: issues operations and observes completion.
  modport master (
    output start, alucode, op1, op2, flush,
    input  busy, done, result
  );

  // Unit side.
  modport slave (
    input  start, alucode, op1, op2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/mul_div_unit_div_core.sv
// Unsigned radix-2 restoring divider: load captures the operands, each
// enabled edge retires one quotient bit (MSB first).
module div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            en,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   partial;
  logic [XLEN:0]   diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // The top bit of diff is the borrow: set means the divisor did not fit.
  assign partial = {rem_q, quo_q[XLEN-1]};
  assign diff    = partial - {1'b0, dvs_q};

  // One restoring step per enable; the dividend register doubles as the
  // quotient shift register.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (en) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= partial[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// RV32M execute unit: fixed-latency multiplier and iterative divider behind
// one FSM. busy drives the pipeline stall; done pulses with a valid result.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);

  localparam logic [5:0]      MUL_LAST = 6'(MUL_LATENCY - 1);
  localparam logic [5:0]      DIV_LAST = 6'(DIV_ITER - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [5:0]      cnt_q;
  alucode_t        code_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic            neg_quo_q, neg_rem_q;
  logic [XLEN-1:0] result_q, result_d;

  // ---------------------------------------------------------------------
  // Request decode (combinational on the incoming operands)
  // ---------------------------------------------------------------------
  logic            idle_or_done;
  logic            accept;
  logic            in_div, in_rem, in_signed;
  logic            in_op1_neg, in_op2_neg;
  logic            in_div_zero, in_overflow, in_special;
  logic [XLEN-1:0] in_special_res;
  logic [XLEN-1:0] mag1, mag2;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  // flush wins over start, so a flushed cycle never latches a new operation.
  assign accept       = bus.start && is_m_op(bus.alucode) && idle_or_done && !bus.flush;

  assign in_div     = is_div_op(bus.alucode);
  assign in_rem     = is_rem_op(bus.alucode);
  assign in_signed  = is_signed_div(bus.alucode);
  assign in_op1_neg = in_signed && bus.op1[XLEN-1];
  assign in_op2_neg = in_signed && bus.op2[XLEN-1];

  assign in_div_zero = (bus.op2 == '0);
  assign in_overflow = in_signed && (bus.op1 == INT_MIN) && (bus.op2 == '1);
  assign in_special  = in_div_zero || in_overflow;

  // Divide-by-zero and INT_MIN/-1 skip the iteration entirely.
  assign in_special_res = in_div_zero ? (in_rem ? bus.op1 : '1)
                                      : (in_rem ? '0      : bus.op1);

  assign mag1 = in_op1_neg ? -bus.op1 : bus.op1;
  assign mag2 = in_op2_neg ? -bus.op2 : bus.op2;

  // ---------------------------------------------------------------------
  // Multiplier: operands are held stable in op*_q for MUL_LATENCY cycles,
  // which is the settling budget of the product path. Only bits [63:0] of
  // the 66-bit signed product are ever selected, so a 64-bit product of the
  // extended operands is exact for every variant.
  // ---------------------------------------------------------------------
  logic              mul_a_sign, mul_b_sign;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;

  assign mul_a_sign = ((code_q == ALU_MULH) || (code_q == ALU_MULHSU)) && op1_q[XLEN-1];
  assign mul_b_sign = (code_q == ALU_MULH) && op2_q[XLEN-1];
  assign mul_a      = {{XLEN{mul_a_sign}}, op1_q};
  assign mul_b      = {{XLEN{mul_b_sign}}, op2_q};
  assign mul_prod   = mul_a * mul_b;

  // ---------------------------------------------------------------------
  // Divider core and sign correction
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] quotient, remainder;
  logic [XLEN-1:0] quo_fix, rem_fix;

  div_core #(.XLEN(XLEN)) u_div_core (
    .clk       (clk),
    .reset     (reset),
    .load      (accept && in_div && !in_special),
    .en        (state_q == ST_DIV),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign quo_fix = neg_quo_q ? -quotient  : quotient;
  assign rem_fix = neg_rem_q ? -remainder : remainder;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides everything except reset.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (!in_div)        state_d = ST_MUL;
          else if (in_special) state_d = ST_DONE;
          else                 state_d = ST_DIV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL:  if (cnt_q == MUL_LAST) state_d = ST_DONE;
      ST_DIV:  if (cnt_q == DIV_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) state_d = ST_IDLE;
  end

  // Shared latency / iteration counter, restarted on every accept.
  always_ff @(posedge clk) begin
    if (reset || bus.flush || accept) cnt_q <= '0;
    else if ((state_q == ST_MUL) || (state_q == ST_DIV)) cnt_q <= cnt_q + 6'd1;
  end

  // Operand and sign capture at the accept edge.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset as well, so reset mid-operation
    // leaves nothing behind that a later operation could observe.
    if (reset) begin
      code_q    <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      code_q    <= bus.alucode;
      op1_q     <= bus.op1;
      op2_q     <= bus.op2;
      neg_quo_q <= in_op1_neg ^ in_op2_neg;
      neg_rem_q <= in_op1_neg;
    end
  end

  // Value presented on the edge that enters DONE.
  always_comb begin
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_DONE: result_d = in_special_res;
      ST_MUL:  result_d = (code_q == ALU_MUL) ? mul_prod[XLEN-1:0]
                                              : mul_prod[2*XLEN-1:XLEN];
      ST_FIX:  result_d = is_rem_op(code_q) ? rem_fix : quo_fix;
      default: result_d = result_q;
    endcase
  end

  // Result register: loads only when entering DONE, so flush leaves it intact.
  always_ff @(posedge clk) begin
    if (reset)                   result_q <= '0;
    else if (state_d == ST_DONE) result_q <= result_d;
  end

  assign bus.busy   = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit. Inputs change on the falling edge and
// outputs are sampled on the falling edge or 1 time unit after a rising edge.
// Latencies count cycles with the cycle that holds start as cycle 0.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = DIV_ITER + 2;

  logic clk = 1'b0;
  logic reset;

  mul_div_unit_if bus ();

  mul_div_unit #(
    .XLEN        (32),
    .MUL_LATENCY (MUL_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request for a single edge; returns 1 unit after that edge.
  task automatic drive_start(input alucode_t code, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.alucode = code;
    bus.op1     = a;
    bus.op2     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; n is the cycle index where done was seen.
  task automatic wait_done(input int n0, output int n, output bit busy_ok);
    bit seen;
    seen    = 1'b0;
    n       = n0;
    busy_ok = 1'b1;
    while (!seen && n <= 80) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else begin
        if (!bus.busy) busy_ok = 1'b0;
        @(posedge clk);
        n++;
      end
    end
  endtask

  task automatic run_op(input string tag, input alucode_t code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    bit busy_ok;
    drive_start(code, a, b);
    check({tag, "_busy_after_accept"}, 32'(bus.busy), 32'(exp_lat > 1));
    wait_done(1, n, busy_ok);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_result"}, bus.result, exp_res);
    if (exp_lat > 1) check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    bit busy_ok;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.alucode = ALU_MUL;
    bus.op1     = '0;
    bus.op2     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);

    // Multiply variants
    run_op("mul_ff",     ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT + 1);
    run_op("mulhu_ff",   ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT + 1);
    run_op("mulh_ff",    ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT + 1);
    run_op("mulhsu_m1",  ALU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT + 1);
    run_op("mul_7x6",    ALU_MUL,    32'd7,         32'd6,         32'd42,        MUL_LAT + 1);

    // Divide / remainder
    run_op("div_m7_2",   ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_m7_2",   ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);

    // Back-to-back: DIVU then REMU issued in the DONE cycle
    drive_start(ALU_DIVU, 32'd100, 32'd7);
    wait_done(1, n, busy_ok);
    check("divu_100_7_latency", 32'(n), 32'(DIV_LAT));
    check("divu_100_7_result", bus.result, 32'd14);
    bus.start   = 1'b1;
    bus.alucode = ALU_REMU;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_accepted_busy", 32'(bus.busy), 32'd1);
    check("b2b_result_held", bus.result, 32'd14);
    wait_done(1, n, busy_ok);
    check("remu_100_7_latency", 32'(n), 32'(DIV_LAT));
    check("remu_100_7_result", bus.result, 32'd2);
    @(posedge clk);

    // Special cases bypass the iteration
    run_op("div_by_zero",  ALU_DIV,  32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_by_zero", ALU_REMU, 32'd5,         32'd0,         32'd5,         1);
    run_op("div_ovf",      ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",      ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // Flush mid-divide: result must keep the MUL value
    run_op("mul_pre_flush", ALU_MUL, 32'd7, 32'd6, 32'd42, MUL_LAT + 1);
    drive_start(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_done", 32'(bus.done), 32'd0);
    check("flush_result_kept", bus.result, 32'd42);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("flush_no_done_pulse", 32'(pulses), 32'd0);

    // Start while busy is ignored
    drive_start(ALU_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.alucode = ALU_MUL;
    bus.op1     = 32'd7;
    bus.op2     = 32'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(6, n, busy_ok);
    check("busy_start_latency", 32'(n), 32'(DIV_LAT));
    check("busy_start_result", bus.result, 32'd14);
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("busy_start_no_extra_done", 32'(pulses), 32'd0);

    // Reset during the multiply stage
    drive_start(ALU_MUL, 32'd7, 32'd6);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_reset_busy", 32'(bus.busy), 32'd0);
    check("mid_reset_done", 32'(bus.done), 32'd0);
    check("mid_reset_result", bus.result, 32'd0);

    // Non-M alucode is not accepted
    drive_start(5'b00000, 32'd3, 32'd4);
    check("non_m_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("non_m_done", 32'(bus.done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
